bus_alu_datapath: RTL and testbench
===================================

// Module: bus_alu_datapath
// PURPOSE
//  Parametrised single-bus datapath: NREGS general registers, Y latch, double-width Z, HI register.
//  Executes one command at a time as a fixed T-step microsequence over one shared bus.
//  Supported commands: LOAD, MOV, ADD, SUB, AND, OR, MUL.
//  Replaces hand-driven Rin/Rout/Zin/Zlowout strobes with an internal sequencer and a valid/ready command port.
// PARAMETERS
//  WIDTH  32  data/register width in bits
//  NREGS  4   number of general registers, 2..16; index fields are 4 bits wide
// PORTS
//  clock      in   1        rising-edge clock; the only clock domain
//  clear      in   1        synchronous, active-high reset
//  cmd_valid  in   1        command present
//  cmd_ready  out  1        high only in S_IDLE
//  cmd_op     in   3        0 LOAD, 1 MOV, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 MUL, 7 reserved
//  cmd_ra     in   4        destination register index
//  cmd_rb     in   4        source A index
//  cmd_rc     in   4        source B index
//  Mdatain    in   WIDTH    LOAD data; sampled in the S_LD cycle, not at accept
//  BusMuxOut  out  WIDTH    current bus value (combinational)
//  RZ         out  2*WIDTH  Z register contents
//  HI         out  WIDTH    high half of the last MUL result
//  done       out  1        one-cycle pulse in the final T-step of a command
//  err        out  1        one-cycle pulse at accept when an index is >= NREGS or op==7
//  rd_sel     in   4        debug read index
//  rd_data    out  WIDTH    R[rd_sel], combinational; 0 when rd_sel >= NREGS
// BEHAVIOUR
//  Reset (clear=1 at an edge)
//   - All R, Y, Z and HI are cleared to 0; state goes to S_IDLE.
//   - done and err are 0; cmd_ready is 1 in the cycle after clear deasserts.
//   - clear during any state aborts the command: no write-back, no done.
//  Accept
//   - A command is accepted when cmd_valid && cmd_ready at a rising edge; op and indices are latched.
//   - cmd_valid while busy is ignored; the command is not queued.
//  Bus
//   - Exactly one source drives the bus per state.
//   - In S_IDLE the bus is 0.
//  Sequence
//   - LOAD: IDLE -> S_LD (bus=Mdatain; R[ra]<=bus; done) -> IDLE.
//   - MOV: IDLE -> S_T1 (bus=R[rb]; R[ra]<=bus; done) -> IDLE.
//   - ALU ops: IDLE -> S_T1 (bus=R[rb]; Y<=bus) -> S_T2 (bus=R[rc]; Z<=alu(Y,bus)) -> S_T3 (bus=Z[W-1:0]; R[ra]<=bus; done) -> IDLE.
//   - MUL adds S_T4 after S_T3 (bus=Z[2W-1:W]; HI<=bus; done moves to S_T4).
//   - Latency from accept edge to done: LOAD/MOV 1 cycle, ADD/SUB/AND/OR 3 cycles, MUL 4 cycles.
//   - cmd_ready rises in the cycle after done; back-to-back commands therefore cost +1 idle cycle.
//  ALU and width rules
//   - ADD: Z = {WIDTH-1 zeros, carry, sum mod 2^WIDTH}.
//   - SUB: Z low = (Y - B) mod 2^WIDTH; Z[WIDTH] = borrow.
//   - AND/OR: Z high = 0.
//   - MUL: unsigned full 2*WIDTH product.
//  Register-index rules
//   - ra == rb (or ra == rc) is legal: sources are read in S_T1/S_T2, before write-back in S_T3.
//   - Error commands (index >= NREGS or op==7): err pulses in the cycle after accept and the FSM runs the normal sequence for that op.
//   - Out-of-range source reads return 0; out-of-range destination writes are suppressed.
//   - op==7 runs a 1-cycle S_T1 with no write and no done.
//  Other outputs
//   - RZ holds its value between commands.
//   - HI changes only on MUL.
// STRUCTURE
//  Package bus_dp_pkg: opcode localparams OP_LOAD..OP_MUL, state encoding S_IDLE/S_LD/S_T1..S_T4.
//  Sub-module bus_alu (combinational; WIDTH param; inputs y, b, op; output z[2W-1:0]).
//  Top holds the register array, bus mux, Y/Z/HI and the sequencer FSM.
// TESTING (WIDTH=32, NREGS=4)
//  1. LOAD R0<-0x10, LOAD R1<-0x20, ADD R2=R0+R1 -> done 3 cycles after accept; rd_data(2)=0x30; RZ=0x30.
//  2. R0=0xFFFFFFFF, R1=1, ADD R3 -> R3=0; RZ=0x1_00000000.
//     SUB R3=R1-R0 -> R3=2; RZ[32]=1.
//  3. R0=0x10000, R1=0x10000, MUL R2 -> R2=0; HI=1; done at cycle 4; RZ=0x1_00000000.
//  4. ADD issued, clear asserted in S_T2 -> no write to R[ra], no done; all regs 0; cmd_ready=1 next cycle.
//  5. cmd_valid held high back-to-back with AND then OR (ra=rb=rc=1) -> second command accepted only after ready;
//     both results correct; intermediate cmd_valid ignored.
//  6. ADD with ra=5 -> err pulses once; R0..R3 unchanged; done still at cycle 3.
//     op=7 -> err pulses; no done.

Source files
------------

// File: rtl/bus_dp_pkg.sv
// Shared opcodes, sequencer states and the latched command bundle
// for the single-bus ALU datapath.
package bus_dp_pkg;

    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_MOV  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_OR   = 3'd5;
    localparam logic [2:0] OP_MUL  = 3'd6;
    localparam logic [2:0] OP_RSV  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LD   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5
    } state_t;

    typedef struct packed {
        logic [2:0] op;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [3:0] rc;
    } cmd_t;

endpackage

// File: rtl/bus_alu_datapath_if.sv
// Command port of the datapath: valid/ready handshake plus
// opcode and register index fields.
interface bus_alu_datapath_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_ra;
    logic [3:0] cmd_rb;
    logic [3:0] cmd_rc;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_ra,
        output cmd_rb,
        output cmd_rc,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_ra,
        input  cmd_rb,
        input  cmd_rc,
        output cmd_ready
    );

endinterface

// File: rtl/bus_alu.sv
// Combinational ALU: Y latch against the bus value, producing a
// double-width result for the Z register.
module bus_alu
    import bus_dp_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   y,
    input  logic [WIDTH-1:0]   b,
    input  logic [2:0]         op,
    output logic [2*WIDTH-1:0] z
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    always_comb begin
        sum  = {1'b0, y} + {1'b0, b};
        // Top bit of the widened difference is the borrow out.
        diff = {1'b0, y} - {1'b0, b};
        z    = '0;
        case (op)
            OP_ADD:  z[WIDTH:0] = sum;
            OP_SUB:  z[WIDTH:0] = diff;
            OP_AND:  z[WIDTH-1:0] = y & b;
            OP_OR:   z[WIDTH-1:0] = y | b;
            OP_MUL:  z = {{WIDTH{1'b0}}, y} * {{WIDTH{1'b0}}, b};
            default: z = '0;
        endcase
    end

endmodule

// File: rtl/bus_alu_datapath.sv
// Single-bus datapath: register file, Y/Z/HI and a sequencer that
// walks each accepted command through its T-steps on one bus.
module bus_alu_datapath
    import bus_dp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREGS = 4
) (
    input  logic                 clock,
    input  logic                 clear,
    bus_alu_datapath_if.slave    cmd,
    input  logic [WIDTH-1:0]     Mdatain,
    output logic [WIDTH-1:0]     BusMuxOut,
    output logic [2*WIDTH-1:0]   RZ,
    output logic [WIDTH-1:0]     HI,
    output logic                 done,
    output logic                 err,
    input  logic [3:0]           rd_sel,
    output logic [WIDTH-1:0]     rd_data
);

    localparam logic [4:0] NR = 5'(NREGS);

    logic [WIDTH-1:0]   regs [NREGS];
    logic [WIDTH-1:0]   y_q;
    logic [2*WIDTH-1:0] z_q;
    logic [WIDTH-1:0]   hi_q;
    logic [2*WIDTH-1:0] alu_z;
    logic [WIDTH-1:0]   rb_val;
    logic [WIDTH-1:0]   rc_val;
    cmd_t               cmd_q;
    state_t             state;
    state_t             nxt;
    logic               we;
    logic               y_en;
    logic               z_en;
    logic               hi_en;
    logic               accept;
    logic               bad;

    assign cmd.cmd_ready = (state == S_IDLE);
    assign accept = (state == S_IDLE) && cmd.cmd_valid;
    assign bad = ({1'b0, cmd.cmd_ra} >= NR) ||
                 ({1'b0, cmd.cmd_rb} >= NR) ||
                 ({1'b0, cmd.cmd_rc} >= NR) ||
                 (cmd.cmd_op == OP_RSV);
    assign RZ = z_q;
    assign HI = hi_q;

    // Indices that never match an entry read as zero.
    always_comb begin
        rb_val  = '0;
        rc_val  = '0;
        rd_data = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (cmd_q.rb == 4'(i)) rb_val = regs[i];
            if (cmd_q.rc == 4'(i)) rc_val = regs[i];
            if (rd_sel == 4'(i)) rd_data = regs[i];
        end
    end

    bus_alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .y (y_q),
        .b (BusMuxOut),
        .op(cmd_q.op),
        .z (alu_z)
    );

    always_comb begin
        nxt       = state;
        BusMuxOut = '0;
        done      = 1'b0;
        we        = 1'b0;
        y_en      = 1'b0;
        z_en      = 1'b0;
        hi_en     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (cmd.cmd_valid)
                    nxt = (cmd.cmd_op == OP_LOAD) ? S_LD : S_T1;
            end
            S_LD: begin
                BusMuxOut = Mdatain;
                we        = 1'b1;
                done      = 1'b1;
                nxt       = S_IDLE;
            end
            S_T1: begin
                BusMuxOut = rb_val;
                if (cmd_q.op == OP_MOV) begin
                    we   = 1'b1;
                    done = 1'b1;
                    nxt  = S_IDLE;
                end else if (cmd_q.op == OP_RSV) begin
                    nxt = S_IDLE;
                end else begin
                    y_en = 1'b1;
                    nxt  = S_T2;
                end
            end
            S_T2: begin
                BusMuxOut = rc_val;
                z_en      = 1'b1;
                nxt       = S_T3;
            end
            S_T3: begin
                BusMuxOut = z_q[WIDTH-1:0];
                we        = 1'b1;
                if (cmd_q.op == OP_MUL) begin
                    nxt = S_T4;
                end else begin
                    done = 1'b1;
                    nxt  = S_IDLE;
                end
            end
            S_T4: begin
                BusMuxOut = z_q[2*WIDTH-1:WIDTH];
                hi_en     = 1'b1;
                done      = 1'b1;
                nxt       = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state <= S_IDLE;
            cmd_q <= '0;
            err   <= 1'b0;
            y_q   <= '0;
            z_q   <= '0;
            hi_q  <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            state <= nxt;
            err   <= accept && bad;
            if (accept)
                cmd_q <= '{op: cmd.cmd_op, ra: cmd.cmd_ra,
                           rb: cmd.cmd_rb, rc: cmd.cmd_rc};
            if (y_en) y_q <= BusMuxOut;
            if (z_en) z_q <= alu_z;
            if (hi_en) hi_q <= BusMuxOut;
            for (int i = 0; i < NREGS; i++)
                if (we && cmd_q.ra == 4'(i)) regs[i] <= BusMuxOut;
        end
    end

endmodule

// File: tb/tb_bus_alu_datapath.sv
// Self-checking bench: directed scenarios with literal expectations,
// then random commands checked against a command-level model.
module tb_bus_alu_datapath;
    import bus_dp_pkg::*;

    localparam int W = 32;
    localparam int N = 4;

    logic          clock = 1'b0;
    logic          clear = 1'b1;
    logic [W-1:0]  Mdatain = '0;
    logic [W-1:0]  bus;
    logic [2*W-1:0] rz;
    logic [W-1:0]  hi;
    logic          done;
    logic          err;
    logic [3:0]    rd_sel = '0;
    logic [W-1:0]  rd_data;
    bit            armed = 1'b0;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;

    bus_alu_datapath_if bif ();

    bus_alu_datapath #(
        .WIDTH(W),
        .NREGS(N)
    ) dut (
        .clock    (clock),
        .clear    (clear),
        .cmd      (bif.slave),
        .Mdatain  (Mdatain),
        .BusMuxOut(bus),
        .RZ       (rz),
        .HI       (hi),
        .done     (done),
        .err      (err),
        .rd_sel   (rd_sel),
        .rd_data  (rd_data)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: no response within cycle budget", nm);
    endtask

    // Command-level reference model, stepped once per cycle at negedge.
    logic [W-1:0]   m_regs [N];
    logic [2*W-1:0] m_rz;
    logic [W-1:0]   m_hi;
    int             m_left;
    bit             m_hasdone, m_err;
    bit             p_we, p_load, p_rzen, p_hien;
    logic [3:0]     p_ra;
    logic [W-1:0]   p_val, p_hi;
    logic [2*W-1:0] p_rz;

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_regs[i] = '0;
        m_rz = '0;
        m_hi = '0;
        m_left = 0;
        m_err = 0;
        m_hasdone = 0;
    endtask

    task automatic model_accept();
        logic [W-1:0]   a, b;
        logic [2*W-1:0] z;
        logic [2:0]     op;
        op = bif.cmd_op;
        a = (bif.cmd_rb < 4'(N)) ? m_regs[bif.cmd_rb[1:0]] : '0;
        b = (bif.cmd_rc < 4'(N)) ? m_regs[bif.cmd_rc[1:0]] : '0;
        m_err = (bif.cmd_ra >= 4'(N)) || (bif.cmd_rb >= 4'(N)) ||
                (bif.cmd_rc >= 4'(N)) || (op == 3'd7);
        p_ra = bif.cmd_ra;
        p_we = 1; p_load = 0; p_rzen = 1; p_hien = 0;
        m_hasdone = 1;
        z = '0;
        case (op)
            3'd0: begin p_load = 1; p_rzen = 0; m_left = 1; end
            3'd1: begin z = {32'd0, a}; p_rzen = 0; m_left = 1; end
            3'd2: begin z = {32'd0, a} + {32'd0, b}; m_left = 3; end
            3'd3: begin z = {31'd0, a < b, a - b}; m_left = 3; end
            3'd4: begin z = {32'd0, a & b}; m_left = 3; end
            3'd5: begin z = {32'd0, a | b}; m_left = 3; end
            3'd6: begin
                z = {32'd0, a} * {32'd0, b};
                p_hien = 1;
                m_left = 4;
            end
            default: begin
                p_we = 0; p_rzen = 0; m_hasdone = 0; m_left = 1;
            end
        endcase
        p_val = z[W-1:0];
        p_rz = z;
        p_hi = z[2*W-1:W];
    endtask

    task automatic model_commit();
        if (p_we && p_ra < 4'(N))
            m_regs[p_ra[1:0]] = p_load ? Mdatain : p_val;
        if (p_rzen) m_rz = p_rz;
        if (p_hien) m_hi = p_hi;
    endtask

    initial begin
        model_reset();
        wait (armed);
        forever begin
            @(negedge clock);
            chk("ready", bif.cmd_ready, m_left == 0);
            chk("done", done, m_left == 1 && m_hasdone);
            chk("err", err, m_err);
            if (m_left == 0) begin
                chk("rz", rz, m_rz);
                chk("hi", hi, m_hi);
                chk("idle_bus", bus, 0);
                chk("rd_data", rd_data,
                    rd_sel < 4'(N) ? m_regs[rd_sel[1:0]] : 32'd0);
            end
            if (done) done_cnt++;
            if (clear) begin
                model_reset();
            end else if (m_left == 0) begin
                m_err = 0;
                if (bif.cmd_valid) model_accept();
            end else begin
                m_err = 0;
                if (m_left == 1) model_commit();
                m_left--;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clock);
        while (!bif.cmd_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!bif.cmd_ready) timeout("wait_idle");
    endtask

    task automatic issue(input logic [2:0] op, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [3:0] rc,
                         input logic [W-1:0] data, output int lat,
                         output int nd, output int ne);
        bit fin = 0;
        lat = 0; nd = 0; ne = 0;
        wait_idle();
        @(posedge clock);
        #1;
        bif.cmd_valid = 1'b1;
        bif.cmd_op = op;
        bif.cmd_ra = ra;
        bif.cmd_rb = rb;
        bif.cmd_rc = rc;
        Mdatain = ~data;
        @(posedge clock);
        #1;
        bif.cmd_valid = 1'b0;
        Mdatain = data;
        for (int i = 1; i <= 12 && !fin; i++) begin
            @(negedge clock);
            if (done) begin nd++; lat = i; end
            if (err) ne++;
            if (bif.cmd_ready) fin = 1;
        end
        if (!fin) timeout("issue");
    endtask

    task automatic rdchk(input logic [3:0] idx, input logic [W-1:0] exp,
                         input string nm);
        @(posedge clock);
        #1 rd_sel = idx;
        @(negedge clock);
        chk(nm, rd_data, exp);
    endtask

    initial begin
        int lat, nd, ne, d0, d1, d2;
        bit dropped;
        bif.cmd_valid = 1'b0;
        bif.cmd_op = '0;
        bif.cmd_ra = '0;
        bif.cmd_rb = '0;
        bif.cmd_rc = '0;
        @(posedge clock);
        #1 armed = 1'b1;
        @(posedge clock);
        #1 clear = 1'b0;
        @(negedge clock);
        chk("rst_ready", bif.cmd_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rz", rz, 0);
        chk("rst_hi", hi, 0);
        for (int i = 0; i < N; i++) rdchk(4'(i), 0, "rst_reg");

        // 1: loads then add
        issue(OP_LOAD, 0, 0, 0, 32'h10, lat, nd, ne);
        chk("t1_ld_lat", lat, 1);
        issue(OP_LOAD, 1, 0, 0, 32'h20, lat, nd, ne);
        issue(OP_ADD, 2, 0, 1, 0, lat, nd, ne);
        chk("t1_add_lat", lat, 3);
        chk("t1_add_ndone", nd, 1);
        rdchk(2, 32'h30, "t1_r2");
        chk("t1_rz", rz, 64'h30);

        // 2: carry and borrow
        issue(OP_LOAD, 0, 0, 0, 32'hFFFF_FFFF, lat, nd, ne);
        issue(OP_LOAD, 1, 0, 0, 32'h1, lat, nd, ne);
        issue(OP_ADD, 3, 0, 1, 0, lat, nd, ne);
        rdchk(3, 32'h0, "t2_add_r3");
        chk("t2_add_rz", rz, 64'h1_0000_0000);
        issue(OP_SUB, 3, 1, 0, 0, lat, nd, ne);
        rdchk(3, 32'h2, "t2_sub_r3");
        chk("t2_sub_rz", rz, 64'h1_0000_0002);

        // 3: multiply
        issue(OP_LOAD, 0, 0, 0, 32'h1_0000, lat, nd, ne);
        issue(OP_LOAD, 1, 0, 0, 32'h1_0000, lat, nd, ne);
        issue(OP_MUL, 2, 0, 1, 0, lat, nd, ne);
        chk("t3_mul_lat", lat, 4);
        rdchk(2, 32'h0, "t3_r2");
        chk("t3_hi", hi, 32'h1);
        chk("t3_rz", rz, 64'h1_0000_0000);

        // 4: clear in S_T2 aborts ADD into R3 (R3 holds 2)
        wait_idle();
        d0 = done_cnt;
        @(posedge clock);
        #1;
        bif.cmd_valid = 1'b1;
        bif.cmd_op = OP_ADD;
        bif.cmd_ra = 3;
        bif.cmd_rb = 0;
        bif.cmd_rc = 1;
        @(posedge clock);
        #1 bif.cmd_valid = 1'b0;
        @(posedge clock);
        #1 clear = 1'b1;
        @(posedge clock);
        #1 clear = 1'b0;
        @(negedge clock);
        chk("t4_ready", bif.cmd_ready, 1);
        chk("t4_no_done", done_cnt - d0, 0);
        chk("t4_rz", rz, 0);
        for (int i = 0; i < N; i++) rdchk(4'(i), 0, "t4_reg");

        // 5: back-to-back AND then OR with valid held high
        issue(OP_LOAD, 1, 0, 0, 32'hA5A5_0F0F, lat, nd, ne);
        wait_idle();
        @(posedge clock);
        #1;
        bif.cmd_valid = 1'b1;
        bif.cmd_op = OP_AND;
        bif.cmd_ra = 1;
        bif.cmd_rb = 1;
        bif.cmd_rc = 1;
        @(posedge clock);
        #1 bif.cmd_op = OP_OR;
        d1 = 0; d2 = 0; dropped = 0;
        for (int i = 1; i <= 15 && d2 == 0; i++) begin
            @(negedge clock);
            if (done) begin
                if (d1 == 0) d1 = i;
                else d2 = i;
            end
            if (bif.cmd_ready && !dropped) begin
                @(posedge clock);
                #1 bif.cmd_valid = 1'b0;
                dropped = 1;
            end
        end
        bif.cmd_valid = 1'b0;
        chk("t5_first_done", d1, 3);
        chk("t5_second_done", d2, 7);
        rdchk(1, 32'hA5A5_0F0F, "t5_r1");
        chk("t5_rz", rz, 64'hA5A5_0F0F);

        // 6: out-of-range destination and reserved op
        issue(OP_ADD, 5, 0, 1, 0, lat, nd, ne);
        chk("t6_err_cnt", ne, 1);
        chk("t6_lat", lat, 3);
        rdchk(0, 0, "t6_r0");
        rdchk(1, 32'hA5A5_0F0F, "t6_r1");
        rdchk(2, 0, "t6_r2");
        rdchk(3, 0, "t6_r3");
        issue(OP_RSV, 0, 0, 0, 0, lat, nd, ne);
        chk("t6_rsv_err", ne, 1);
        chk("t6_rsv_ndone", nd, 0);

        // Random traffic, model-checked every cycle
        for (int c = 0; c < 3000; c++) begin
            @(posedge clock);
            #1;
            bif.cmd_valid = ($urandom_range(0, 3) != 0);
            bif.cmd_op = 3'($urandom_range(0, 7));
            bif.cmd_ra = ($urandom_range(0, 9) == 0) ?
                         4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
            bif.cmd_rb = ($urandom_range(0, 9) == 0) ?
                         4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
            bif.cmd_rc = ($urandom_range(0, 9) == 0) ?
                         4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: Mdatain = 32'hFFFF_FFFF;
                1: Mdatain = 32'($urandom_range(0, 3));
                default: Mdatain = $urandom;
            endcase
            rd_sel = 4'($urandom_range(0, 7));
            clear = ($urandom_range(0, 99) == 0);
        end
        @(posedge clock);
        #1;
        clear = 1'b0;
        bif.cmd_valid = 1'b0;
        wait_idle();
        @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
